uart_tx_fifo_ctrl: RTL and testbench

//   Byte FIFO plus launch controller placed directly upstream of UART_rs232_tx.

---
 rtl/uart_tx_fifo_ctrl.sv | 133 +++++++++++++
 tb/tb_uart_tx_fifo_ctrl.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_ctrl.sv
// Byte FIFO feeding UART_rs232_tx: pops bytes in order and runs the TxEn/TxDone
// handshake one frame at a time, with an optional idle gap after each frame.
module uart_tx_fifo_ctrl #(
  parameter int DATA_W     = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_W     = 4,
  parameter int GAP_CYCLES = 0
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic [DATA_W-1:0] WrData,
  input  logic              WrEn,
  input  logic              Flush,
  output logic              Full,
  output logic              Empty,
  output logic [ADDR_W:0]   Count,
  output logic              Overflow,
  output logic              Busy,
  output logic              TxEn,
  output logic [DATA_W-1:0] TxData,
  input  logic              TxDone
);

  localparam int unsigned GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [ADDR_W:0]  DEPTH_C    = (ADDR_W + 1)'(DEPTH);
  localparam logic [GAP_W-1:0] GAP_LAST_C = GAP_W'(GAP_LAST);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, DRAIN, GAP} state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q;
  logic              txen_q;
  logic [DATA_W-1:0] txdata_q;
  logic [GAP_W-1:0]  gap_q;
  state_t            state_q;
  logic              wr_acc, pop;

  assign Full     = (count_q == DEPTH_C);
  assign Empty    = (count_q == '0);
  assign Count    = count_q;
  assign Overflow = overflow_q;
  assign Busy     = (state_q != IDLE);
  assign TxEn     = txen_q;
  assign TxData   = txdata_q;

  // Flush wins over both a same-cycle write and the LOAD pop.
  assign wr_acc = WrEn && !Full && !Flush;
  assign pop    = (state_q == LOAD) && !Flush && !Empty;

  always_comb begin
    count_d = count_q;
    if (Flush) begin
      count_d = '0;
    end else begin
      case ({wr_acc, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= WrData;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      overflow_q <= WrEn && Full && !Flush;
      if (Flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (wr_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q  <= IDLE;
      txen_q   <= 1'b0;
      txdata_q <= '0;
      gap_q    <= '0;
    end else begin
      case (state_q)
        IDLE: if (!Empty) state_q <= LOAD;
        LOAD: begin
          if (pop) begin
            txdata_q <= mem_q[rd_ptr_q];
            txen_q   <= 1'b1;
            state_q  <= SEND;
          end else begin
            state_q  <= IDLE;
          end
        end
        SEND: begin
          if (TxDone) begin
            txen_q  <= 1'b0;
            state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // Serializer must drop TxDone before the next frame can be requested.
          if (!TxDone) begin
            if (GAP_CYCLES > 0) begin
              gap_q   <= '0;
              state_q <= GAP;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        GAP: begin
          if (gap_q == GAP_LAST_C) state_q <= IDLE;
          else                     gap_q   <= gap_q + 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Directed bench for uart_tx_fifo_ctrl: cycle table plus multi-cycle sequences
// for reset, single frame, burst, full/overflow, flush and inter-frame gap.
module tb_uart_tx_fifo_ctrl;

  logic       Clk, Rst_n;
  logic [7:0] wr_data;
  logic       wr_en, flush;
  logic       full, empty, overflow, busy, tx_en, tx_done;
  logic [4:0] count;
  logic [7:0] tx_data;

  logic       ser_auto, done_man, done_auto;
  int         ser_dly, ser_cnt;

  logic [7:0] g_wr_data;
  logic       g_wr_en, g_flush;
  logic       g_full, g_empty, g_overflow, g_busy, g_tx_en, g_done;
  logic [4:0] g_count;
  logic [7:0] g_tx_data;
  int         g_cnt;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  assign tx_done = ser_auto ? done_auto : done_man;

  uart_tx_fifo_ctrl #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .GAP_CYCLES(0)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .WrData(wr_data), .WrEn(wr_en), .Flush(flush),
    .Full(full), .Empty(empty), .Count(count), .Overflow(overflow), .Busy(busy),
    .TxEn(tx_en), .TxData(tx_data), .TxDone(tx_done)
  );

  uart_tx_fifo_ctrl #(.DATA_W(8), .DEPTH(16), .ADDR_W(4), .GAP_CYCLES(10415)) dut_g (
    .Clk(Clk), .Rst_n(Rst_n), .WrData(g_wr_data), .WrEn(g_wr_en), .Flush(g_flush),
    .Full(g_full), .Empty(g_empty), .Count(g_count), .Overflow(g_overflow), .Busy(g_busy),
    .TxEn(g_tx_en), .TxData(g_tx_data), .TxDone(g_done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Serializer models: raise TxDone ser_dly cycles into a frame, drop it once TxEn falls.
  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      ser_cnt <= 0; done_auto <= 1'b0;
    end else if (done_auto) begin
      if (!tx_en) done_auto <= 1'b0;
    end else if (ser_auto && tx_en) begin
      if (ser_cnt >= ser_dly - 1) begin done_auto <= 1'b1; ser_cnt <= 0; end
      else ser_cnt <= ser_cnt + 1;
    end
  end

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      g_cnt <= 0; g_done <= 1'b0;
    end else if (g_done) begin
      if (!g_tx_en) g_done <= 1'b0;
    end else if (g_tx_en) begin
      if (g_cnt >= 19) begin g_done <= 1'b1; g_cnt <= 0; end
      else g_cnt <= g_cnt + 1;
    end
  end

  logic [7:0] frames[$];
  logic       txen_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;
  logic       track = 1'b0;
  int         cnt_max = 0;
  logic       g_done_prev = 1'b0, g_txen_prev = 1'b0;
  int         g_fall_cyc = 0, g_rise_cyc = 0, g_rises = 0;
  logic [7:0] g_last_data = 8'h00;

  always @(negedge Clk) begin
    if (tx_en && !txen_prev) frames.push_back(tx_data);
    if (tx_en && txen_prev) check("txdata_stable", {24'b0, tx_data}, {24'b0, data_prev});
    txen_prev = tx_en;
    data_prev = tx_data;
    if (track && int'(count) > cnt_max) cnt_max = int'(count);
    if (g_done_prev && !g_done) g_fall_cyc = cyc;
    if (g_tx_en && !g_txen_prev) begin
      g_rises++; g_rise_cyc = cyc; g_last_data = g_tx_data;
    end
    g_done_prev = g_done;
    g_txen_prev = g_tx_en;
  end

  typedef struct {
    logic       we;  logic [7:0] wd; logic fl; logic dn;
    logic [4:0] cnt; logic emp; logic ful; logic ovf; logic ten; logic [7:0] tdat; logic bsy;
  } vec_t;

  function automatic vec_t mk(input int we, input int wd, input int fl, input int dn,
                              input int cnt, input int emp, input int ful, input int ovf,
                              input int ten, input int tdat, input int bsy);
    vec_t v;
    v.we = we[0]; v.wd = wd[7:0]; v.fl = fl[0]; v.dn = dn[0];
    v.cnt = cnt[4:0]; v.emp = emp[0]; v.ful = ful[0]; v.ovf = ovf[0];
    v.ten = ten[0]; v.tdat = tdat[7:0]; v.bsy = bsy[0];
    return v;
  endfunction

  task automatic wait_idle(input int limit, input string nm);
    int n = 0;
    while ((busy || !empty) && n < limit) begin @(posedge Clk); #1; n++; end
    check(nm, {31'b0, !busy && empty}, 32'd1);
  endtask

  vec_t vt[19];
  logic [7:0] hello[5];

  initial begin
    //            we  wd   fl dn  cnt emp ful ovf ten tdat bsy
    vt[0]  = mk(1, 'h48, 0, 0,  1, 0, 0, 0, 0, 'h00, 0);
    vt[1]  = mk(1, 'h45, 0, 0,  2, 0, 0, 0, 0, 'h00, 1);
    vt[2]  = mk(1, 'h4C, 0, 0,  2, 0, 0, 0, 1, 'h48, 1);
    vt[3]  = mk(1, 'h4F, 0, 0,  3, 0, 0, 0, 1, 'h48, 1);
    vt[4]  = mk(0, 'h00, 0, 1,  3, 0, 0, 0, 0, 'h48, 1);
    vt[5]  = mk(0, 'h00, 0, 1,  3, 0, 0, 0, 0, 'h48, 1);
    vt[6]  = mk(0, 'h00, 0, 0,  3, 0, 0, 0, 0, 'h48, 0);
    vt[7]  = mk(0, 'h00, 0, 1,  3, 0, 0, 0, 0, 'h48, 1);
    vt[8]  = mk(1, 'h21, 0, 1,  3, 0, 0, 0, 1, 'h45, 1);
    vt[9]  = mk(0, 'h00, 0, 0,  3, 0, 0, 0, 1, 'h45, 1);
    vt[10] = mk(0, 'h00, 1, 0,  0, 1, 0, 0, 1, 'h45, 1);
    vt[11] = mk(1, 'h55, 1, 0,  0, 1, 0, 0, 1, 'h45, 1);
    vt[12] = mk(0, 'h00, 0, 1,  0, 1, 0, 0, 0, 'h45, 1);
    vt[13] = mk(0, 'h00, 0, 0,  0, 1, 0, 0, 0, 'h45, 0);
    vt[14] = mk(0, 'h00, 0, 0,  0, 1, 0, 0, 0, 'h45, 0);
    vt[15] = mk(1, 'h66, 0, 0,  1, 0, 0, 0, 0, 'h45, 0);
    vt[16] = mk(0, 'h00, 0, 0,  1, 0, 0, 0, 0, 'h45, 1);
    vt[17] = mk(0, 'h00, 1, 0,  0, 1, 0, 0, 0, 'h45, 0);
    vt[18] = mk(0, 'h00, 0, 0,  0, 1, 0, 0, 0, 'h45, 0);
    hello[0] = 8'h48; hello[1] = 8'h45; hello[2] = 8'h4C; hello[3] = 8'h4C; hello[4] = 8'h4F;

    Rst_n = 1'b0; wr_en = 1'b0; wr_data = '0; flush = 1'b0;
    ser_auto = 1'b0; done_man = 1'b0; ser_dly = 1000;
    g_wr_en = 1'b0; g_wr_data = '0; g_flush = 1'b0;

    repeat (3) @(negedge Clk);
    check("rst_txen", {31'b0, tx_en}, 32'd0);
    check("rst_txdata", {24'b0, tx_data}, 32'd0);
    check("rst_empty", {31'b0, empty}, 32'd1);
    check("rst_count", {27'b0, count}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    Rst_n = 1'b1;
    @(negedge Clk);

    foreach (vt[i]) begin
      wr_en = vt[i].we; wr_data = vt[i].wd; flush = vt[i].fl; done_man = vt[i].dn;
      @(posedge Clk); #1;
      check($sformatf("tbl%0d_count", i), {27'b0, count}, {27'b0, vt[i].cnt});
      check($sformatf("tbl%0d_empty", i), {31'b0, empty}, {31'b0, vt[i].emp});
      check($sformatf("tbl%0d_full", i), {31'b0, full}, {31'b0, vt[i].ful});
      check($sformatf("tbl%0d_ovf", i), {31'b0, overflow}, {31'b0, vt[i].ovf});
      check($sformatf("tbl%0d_txen", i), {31'b0, tx_en}, {31'b0, vt[i].ten});
      check($sformatf("tbl%0d_txdata", i), {24'b0, tx_data}, {24'b0, vt[i].tdat});
      check($sformatf("tbl%0d_busy", i), {31'b0, busy}, {31'b0, vt[i].bsy});
      @(negedge Clk);
    end
    wr_en = 1'b0; flush = 1'b0; done_man = 1'b0;

    // Asynchronous reset while a frame is in SEND with bytes still queued.
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk); wr_en = 1'b1; wr_data = 8'hA1 + 8'(i);
    end
    @(negedge Clk); wr_en = 1'b0;
    begin
      int n = 0;
      while (!tx_en && n < 10) begin @(negedge Clk); n++; end
      check("mid_send_reached", {31'b0, tx_en}, 32'd1);
    end
    #2 Rst_n = 1'b0;
    #1;
    check("arst_txen", {31'b0, tx_en}, 32'd0);
    check("arst_txdata", {24'b0, tx_data}, 32'd0);
    check("arst_empty", {31'b0, empty}, 32'd1);
    check("arst_count", {27'b0, count}, 32'd0);
    check("arst_busy", {31'b0, busy}, 32'd0);
    @(negedge Clk); Rst_n = 1'b1;
    @(negedge Clk);
    frames.delete();

    // Single byte against a 1000-cycle serializer.
    ser_auto = 1'b1; ser_dly = 1000;
    wr_en = 1'b1; wr_data = 8'h48;
    @(posedge Clk); #1 check("sb_e0_txen", {31'b0, tx_en}, 32'd0);
    @(negedge Clk); wr_en = 1'b0;
    @(posedge Clk); #1 check("sb_e1_txen", {31'b0, tx_en}, 32'd0);
    @(posedge Clk); #1 check("sb_e2_txen", {31'b0, tx_en}, 32'd1);
    check("sb_e2_txdata", {24'b0, tx_data}, 32'h48);
    begin
      int n = 0;
      while (!tx_done && n < 1100) begin @(posedge Clk); #1; n++; end
      check("sb_done_seen", {31'b0, tx_done}, 32'd1);
    end
    check("sb_txen_at_done", {31'b0, tx_en}, 32'd1);
    @(posedge Clk); #1 check("sb_txen_fall", {31'b0, tx_en}, 32'd0);
    wait_idle(20, "sb_idle");
    check("sb_frames", frames.size(), 32'd1);
    if (frames.size() > 0) check("sb_frame0", {24'b0, frames[0]}, 32'h48);

    // Burst "HELLO" on consecutive cycles.
    @(negedge Clk);
    frames.delete(); ser_dly = 50; cnt_max = 0; track = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = hello[i];
      @(negedge Clk);
    end
    wr_en = 1'b0;
    wait_idle(2000, "burst_idle");
    track = 1'b0;
    check("burst_frames", frames.size(), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < frames.size()) check($sformatf("burst_frame%0d", i), {24'b0, frames[i]}, {24'b0, hello[i]});
    check("burst_peak_4_or_5", {31'b0, cnt_max == 4 || cnt_max == 5}, 32'd1);
    check("burst_count_end", {27'b0, count}, 32'd0);
    check("burst_empty_end", {31'b0, empty}, 32'd1);

    // Fill with TxDone stuck low: first byte sits in SEND, 16 more fill the FIFO.
    @(negedge Clk);
    frames.delete(); ser_auto = 1'b0; done_man = 1'b0;
    for (int i = 0; i < 18; i++) begin
      wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
      @(posedge Clk); #1;
      if (i == 15) begin
        check("fill16_count", {27'b0, count}, 32'd15);
        check("fill16_full", {31'b0, full}, 32'd0);
      end
      if (i == 16) begin
        check("fill17_count", {27'b0, count}, 32'd16);
        check("fill17_full", {31'b0, full}, 32'd1);
        check("fill17_ovf", {31'b0, overflow}, 32'd0);
      end
      if (i == 17) begin
        check("drop_ovf", {31'b0, overflow}, 32'd1);
        check("drop_count", {27'b0, count}, 32'd16);
      end
      @(negedge Clk);
    end
    wr_en = 1'b0;
    @(posedge Clk); #1;
    check("ovf_pulse_end", {31'b0, overflow}, 32'd0);
    check("full_count_hold", {27'b0, count}, 32'd16);
    check("full_txdata", {24'b0, tx_data}, 32'h10);

    // Flush during SEND: queue discarded, current frame still finishes.
    @(negedge Clk); flush = 1'b1;
    @(posedge Clk); #1;
    check("flush_count", {27'b0, count}, 32'd0);
    check("flush_empty", {31'b0, empty}, 32'd1);
    check("flush_txen_kept", {31'b0, tx_en}, 32'd1);
    check("flush_txdata_kept", {24'b0, tx_data}, 32'h10);
    @(negedge Clk); flush = 1'b0; done_man = 1'b1;
    @(posedge Clk); #1 check("flush_frame_end", {31'b0, tx_en}, 32'd0);
    @(negedge Clk); done_man = 1'b0;
    wait_idle(10, "flush_idle");
    repeat (5) @(negedge Clk);
    check("flush_no_more_txen", {31'b0, tx_en || busy}, 32'd0);
    check("flush_frames", frames.size(), 32'd1);

    // Inter-character gap on the GAP_CYCLES=10415 instance.
    @(negedge Clk); g_wr_en = 1'b1; g_wr_data = 8'hC1;
    @(negedge Clk); g_wr_data = 8'hC2;
    @(negedge Clk); g_wr_en = 1'b0;
    begin
      int n = 0;
      while (g_rises < 2 && n < 12000) begin @(negedge Clk); n++; end
      check("gap_second_frame", {31'b0, g_rises >= 2}, 32'd1);
    end
    check("gap_min", {31'b0, (g_rise_cyc - g_fall_cyc) >= 10415}, 32'd1);
    check("gap_max", {31'b0, (g_rise_cyc - g_fall_cyc) <= 10425}, 32'd1);
    check("gap_data", {24'b0, g_last_data}, 32'hC2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
